// File: rtl/dotprod_sched_pkg.sv
// dotprod_sched_pkg: shared types for the dotprod job sequencer.
package dotprod_sched_pkg;

  localparam int unsigned DONE_CNT_W = 16;
  localparam int unsigned JOB_TAG_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0]          n;
    logic [JOB_TAG_W-1:0] tag;
  } job_t;

endpackage

// File: rtl/dotprod_job_fifo.sv
// dotprod_job_fifo: synchronous DEPTH-entry job queue with full/empty flags.
// Push is ignored when full, pop is ignored when empty.
import dotprod_sched_pkg::*;

module dotprod_job_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  job_t wr_job,
  input  logic pop,
  output job_t rd_job,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  job_t          mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_job  = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_job;
  end

endmodule

// File: rtl/dotprod_job_sched.sv
// dotprod_job_sched: queues dot-product jobs and drives one dotprod kernel
// through ap_ctrl_hs, returning each result with its tag on a valid/ready port.
// Optional per-job watchdog: define DOTPROD_TIMEOUT_EN.
import dotprod_sched_pkg::*;

module dotprod_job_sched #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TAG_W          = JOB_TAG_W,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [31:0]           job_n,
  input  logic [TAG_W-1:0]      job_tag,
  output logic                  k_ap_start,
  output logic [31:0]           k_n,
  input  logic                  k_ap_done,
  input  logic                  k_ap_idle,
  input  logic [31:0]           k_ap_return,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [31:0]           res_data,
  output logic [TAG_W-1:0]      res_tag,
  output logic                  res_timeout,
  output logic                  busy,
  output logic [DONE_CNT_W-1:0] done_cnt
);

  if (TAG_W != JOB_TAG_W) begin : g_tag_w_check
    $error("TAG_W must match JOB_TAG_W in dotprod_sched_pkg");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be non-zero");
  end

  state_t state;
  job_t   in_job;
  job_t   head_job;
  logic   fifo_full;
  logic   fifo_empty;
  logic   pop;

  assign in_job.n   = job_n;
  assign in_job.tag = job_tag;

  // job_ready reflects fullness before any same-cycle pop.
  assign job_ready = !fifo_full;
  assign pop       = (state == IDLE) && !fifo_empty && k_ap_idle;
  assign busy      = !fifo_empty || (state != IDLE);

  dotprod_job_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (ap_clk),
    .rst_n  (ap_rst_n),
    .push   (job_valid),
    .wr_job (in_job),
    .pop    (pop),
    .rd_job (head_job),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

`ifdef DOTPROD_TIMEOUT_EN
  // Counter starts at 0 in the first RUN cycle, so expiry at TIMEOUT_CYCLES-1
  // means TIMEOUT_CYCLES RUN cycles have elapsed without k_ap_done.
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] wd_cnt;

  // Watchdog: counts RUN cycles, cleared whenever the FSM is elsewhere.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)          wd_cnt <= '0;
    else if (state != RUN)  wd_cnt <= '0;
    else                    wd_cnt <= wd_cnt + 32'd1;
  end
`endif

  // Sequencer FSM with registered kernel and result outputs.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state       <= IDLE;
      k_ap_start  <= 1'b0;
      k_n         <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_tag     <= '0;
      res_timeout <= 1'b0;
      done_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            res_tag     <= head_job.tag;
            res_timeout <= 1'b0;
            if (head_job.n == '0) begin
              res_data  <= '0;
              res_valid <= 1'b1;
              state     <= OUT;
            end else begin
              k_n        <= head_job.n;
              k_ap_start <= 1'b1;
              state      <= RUN;
            end
          end
        end
        RUN: begin
          if (k_ap_done) begin
            res_data   <= k_ap_return;
            k_ap_start <= 1'b0;
            res_valid  <= 1'b1;
            state      <= OUT;
          end
`ifdef DOTPROD_TIMEOUT_EN
          else if (wd_cnt == WD_LAST) begin
            res_data    <= '0;
            res_timeout <= 1'b1;
            k_ap_start  <= 1'b0;
            res_valid   <= 1'b1;
            state       <= OUT;
          end
`endif
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            done_cnt  <= done_cnt + DONE_CNT_W'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dotprod_job_sched.sv
// tb_dotprod_job_sched: randomized and directed checks of the job sequencer
// against a queue-based reference model and a behavioural ap_ctrl_hs kernel.
`timescale 1ns/1ps

module tb_dotprod_job_sched;

  localparam int unsigned TO_CYC = 16;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        job_valid;
  logic        job_ready;
  logic [31:0] job_n;
  logic [3:0]  job_tag;
  logic        k_ap_start;
  logic [31:0] k_n;
  logic        k_ap_done;
  logic        k_ap_idle;
  logic [31:0] k_ap_return;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [3:0]  res_tag;
  logic        res_timeout;
  logic        busy;
  logic [15:0] done_cnt;

  dotprod_job_sched #(
    .DEPTH          (4),
    .TAG_W          (4),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .job_valid   (job_valid),
    .job_ready   (job_ready),
    .job_n       (job_n),
    .job_tag     (job_tag),
    .k_ap_start  (k_ap_start),
    .k_n         (k_n),
    .k_ap_done   (k_ap_done),
    .k_ap_idle   (k_ap_idle),
    .k_ap_return (k_ap_return),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_tag     (res_tag),
    .res_timeout (res_timeout),
    .busy        (busy),
    .done_cnt    (done_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Kernel arithmetic: a small dot product of two fixed sequences over n[5:0]
  // elements, folded with the high bits of n so every n bit matters.
  function automatic logic [31:0] kfunc(input logic [31:0] n);
    logic [31:0] acc;
    acc = 32'h0;
    for (int i = 0; i < int'(n[5:0]); i++)
      acc = acc + 32'((i + 1) * (2 * i + 3));
    return acc ^ {n[31:6], 6'b0};
  endfunction

  // ---------------- kernel model (ap_ctrl_hs) ----------------
  bit          k_run = 0, k_hold = 0, k_hang = 0, k_spur = 0, k_rand_lat = 0, k_prev = 0;
  int unsigned k_cnt = 0, k_lat = 10, k_lat_cur = 10, k_starts = 0;
  logic [31:0] k_n_lat = '0;

  assign k_ap_idle = !k_run && !k_hold;

  initial begin
    k_ap_done   = 1'b0;
    k_ap_return = 32'hDEAD_BEEF;
  end

  always @(negedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      k_run = 0; k_prev = 0; k_ap_done = 1'b0; k_ap_return = 32'hDEAD_BEEF;
    end else begin
      if (k_ap_start && !k_prev) k_starts++;
      k_prev = k_ap_start;
      if (k_run) begin
        if (k_ap_start) check("k_n_stable", k_n, k_n_lat);
        if (k_ap_done) begin
          k_ap_done = 1'b0; k_ap_return = 32'hDEAD_BEEF; k_run = 0;
        end else begin
          k_cnt++;
          if (k_cnt == k_lat_cur) begin
            k_ap_done = 1'b1; k_ap_return = kfunc(k_n_lat);
          end
        end
      end else begin
        k_ap_done = 1'b0;
        if (k_ap_start && !k_hang) begin
          k_run = 1; k_cnt = 0; k_n_lat = k_n;
          k_lat_cur = k_rand_lat ? $urandom_range(1, 8) : k_lat;
        end else if (k_spur) begin
          k_ap_done = 1'b1; k_spur = 0;
        end
      end
    end
  end

  // ---------------- reference model / result scoreboard ----------------
  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    logic        to;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] exp_done = '0;

  always @(negedge ap_clk) begin
    if (ap_rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", res_valid, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        check("res_data", res_data, mon_e.data);
        check("res_tag", res_tag, mon_e.tag);
        check("res_timeout", res_timeout, mon_e.to);
      end
      exp_done = exp_done + 16'd1;
      if (res_timeout) k_hang = 0;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_job(input logic [31:0] n, input logic [3:0] tag, input logic to);
    int unsigned w = 0;
    exp_t e;
    job_valid = 1'b1; job_n = n; job_tag = tag;
    while (!job_ready && w < 300) begin @(negedge ap_clk); w++; end
    if (!job_ready) begin
      check("push_wait", job_ready, 1'b1);
      job_valid = 1'b0;
      return;
    end
    e.data = (n == 0 || to) ? 32'h0 : kfunc(n);
    e.tag  = tag;
    e.to   = to;
    exp_q.push_back(e);
    @(posedge ap_clk);
    @(negedge ap_clk);
    job_valid = 1'b0;
  endtask

  task automatic set_ready(input logic v);
    @(posedge ap_clk);
    #1 res_ready = v;
  endtask

  task automatic wait_valid(input string tag, input int unsigned lim);
    int unsigned w = 0;
    while (!res_valid && w < lim) begin @(negedge ap_clk); w++; end
    check(tag, res_valid, 1'b1);
  endtask

  task automatic drain(input string tag);
    int unsigned w = 0;
    while ((exp_q.size() != 0 || busy) && w < 3000) begin @(negedge ap_clk); w++; end
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_queue"}, exp_q.size(), 0);
    @(negedge ap_clk);
    check({tag, "_done_cnt"}, done_cnt, exp_done);
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  int unsigned s0, w;
  bit          rand_done;

  initial begin
    job_valid = 1'b0; job_n = '0; job_tag = '0; res_ready = 1'b1; ap_rst_n = 1'b0;
    #1;
    check("rst_job_ready", job_ready, 1'b1);
    check("rst_k_ap_start", k_ap_start, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_data", res_data, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done_cnt", done_cnt, 16'h0);
    check("rst_res_timeout", res_timeout, 1'b0);
    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);

    // Single job: exact start window and result latency.
    k_lat = 10; s0 = k_starts;
    push_job(32'd8, 4'd3, 1'b0);
    check("t1_start_before", k_ap_start, 1'b0);
    for (int i = 2; i <= 12; i++) begin
      @(negedge ap_clk);
      check("t1_start_high", k_ap_start, 1'b1);
    end
    @(negedge ap_clk);
    check("t1_start_drop", k_ap_start, 1'b0);
    check("t1_res_valid", res_valid, 1'b1);
    check("t1_res_data", res_data, kfunc(32'd8));
    check("t1_res_tag", res_tag, 4'd3);
    @(negedge ap_clk);
    check("t1_done_cnt", done_cnt, 16'd1);
    check("t1_kstarts", k_starts - s0, 1);

    // Zero-length job bypasses the kernel.
    s0 = k_starts;
    push_job(32'd0, 4'd7, 1'b0);
    check("z_res_valid_early", res_valid, 1'b0);
    @(negedge ap_clk);
    check("z_res_valid", res_valid, 1'b1);
    check("z_res_data", res_data, 32'h0);
    check("z_res_tag", res_tag, 4'd7);
    @(negedge ap_clk);
    check("z_no_start", k_starts - s0, 0);

    // Done pulse outside RUN is ignored.
    k_spur = 1;
    repeat (4) @(negedge ap_clk);
    check("spur_res_valid", res_valid, 1'b0);
    check("spur_busy", busy, 1'b0);

    // Result backpressure: output held, no new start, count frozen.
    set_ready(1'b0);
    @(negedge ap_clk);
    push_job(32'd6, 4'd9, 1'b0);
    wait_valid("bp_valid", 100);
    push_job(32'd3, 4'd4, 1'b0);
    s0 = k_starts;
    for (int i = 0; i < 20; i++) begin
      @(negedge ap_clk);
      check("bp_valid_hold", res_valid, 1'b1);
      check("bp_data_hold", res_data, kfunc(32'd6));
      check("bp_tag_hold", res_tag, 4'd9);
    end
    check("bp_no_start", k_starts - s0, 0);
    check("bp_done_cnt", done_cnt, exp_done);
    set_ready(1'b1);
    @(negedge ap_clk);
    drain("bp");

    // Fill the queue while the kernel reports busy.
    k_hold = 1;
    for (int i = 1; i <= 4; i++) push_job(32'($urandom_range(1, 20)), 4'(i), 1'b0);
    check("full_ready", job_ready, 1'b0);
    check("full_busy", busy, 1'b1);
    fork
      push_job(32'd11, 4'd5, 1'b0);
      begin
        repeat (5) @(negedge ap_clk);
        check("full_ready_hold", job_ready, 1'b0);
        k_hold = 0;
      end
    join
    drain("fill");

    // Reset while the kernel is running.
    k_lat = 50;
    push_job(32'd10, 4'd5, 1'b0);
    w = 0;
    while (!k_ap_start && w < 20) begin @(negedge ap_clk); w++; end
    check("rr_started", k_ap_start, 1'b1);
    repeat (5) @(negedge ap_clk);
    #2 ap_rst_n = 1'b0;
    #1;
    check("rr_k_ap_start", k_ap_start, 1'b0);
    check("rr_res_valid", res_valid, 1'b0);
    exp_q.delete();
    exp_done = '0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("rr_busy", busy, 1'b0);
    check("rr_job_ready", job_ready, 1'b1);
    check("rr_done_cnt", done_cnt, 16'h0);
    k_lat = 10;

    // Randomized jobs, latencies and consumer readiness.
    k_rand_lat = 1; rand_done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [31:0] n;
          case ($urandom_range(0, 3))
            0:       n = 32'h0;
            1:       n = $urandom;
            default: n = 32'($urandom_range(1, 40));
          endcase
          push_job(n, 4'($urandom), 1'b0);
          repeat ($urandom_range(0, 2)) @(negedge ap_clk);
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge ap_clk);
          #1 res_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    set_ready(1'b1);
    @(negedge ap_clk);
    drain("rand");
    k_rand_lat = 0;

`ifdef DOTPROD_TIMEOUT_EN
    // Kernel never finishes: watchdog returns a timed-out result, next job runs.
    s0 = k_starts;
    k_hang = 1;
    push_job(32'd3, 4'd1, 1'b1);
    push_job(32'd4, 4'd2, 1'b0);
    drain("to");
    check("to_starts", k_starts - s0, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
